// File: rtl/cpu.sv
// cpu: 16-bit multi-cycle core, 8x16 register file, zero flag, one fetch port.
// Ports: clk, rst (sync, active-low), en_in (start), en_ram_out/ins (RAM
//        instruction valid/data), en_ram_in (fetch request), addr (= pc).
module cpu (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic        en_ram_out,
    input  logic [15:0] ins,
    output logic        en_ram_in,
    output logic [15:0] addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_MOV  = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_JMP  = 5'b10101;
    localparam logic [4:0] OP_BZ   = 5'b10110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] gr_q [8];
    logic [15:0] gr_d [8];
    logic        zf_q, zf_d;

    // Architectural state under its plain names
    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] gr [8];
    logic        zf;

    assign state = state_q;
    assign pc    = pc_q;
    assign ir    = ir_q;
    assign gr    = gr_q;
    assign zf    = zf_q;

    logic [4:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm8;
    logic [10:0] imm11;
    logic [15:0] a, b, res;

    assign op    = ir[15:11];
    assign rd    = ir[10:8];
    assign rs    = ir[7:5];
    assign rt    = ir[4:2];
    assign imm8  = ir[7:0];
    assign imm11 = ir[10:0];
    assign a     = gr[rs];
    assign b     = gr[rt];

    assign addr  = pc;

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        gr_d      = gr_q;
        zf_d      = zf;
        en_ram_in = 1'b0;
        res       = 16'h0000;
        case (state)
            IDLE: begin
                if (en_in) state_d = FETCH;
            end
            FETCH: begin
                en_ram_in = 1'b1;
                if (en_ram_out) begin
                    ir_d    = ins;
                    pc_d    = pc + 16'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (op == OP_HALT) ? HALT : FETCH;
                case (op)
                    OP_LDI: gr_d[rd] = {8'h00, imm8};
                    OP_MOV: gr_d[rd] = a;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                        case (op)
                            OP_ADD:  res = a + b;
                            OP_SUB:  res = a - b;
                            OP_AND:  res = a & b;
                            OP_OR:   res = a | b;
                            OP_XOR:  res = a ^ b;
                            default: res = gr[rd] + {8'h00, imm8};
                        endcase
                        gr_d[rd] = res;
                        zf_d     = (res == 16'h0000);
                    end
                    OP_JMP: pc_d = {5'b00000, imm11};
                    // pc already points past the branch here
                    OP_BZ: if (zf) pc_d = pc + {{8{imm8[7]}}, imm8};
                    OP_NOP, OP_HALT: ;
                    default: ;
                endcase
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= 16'h0000;
            ir_q    <= 16'h0000;
            zf_q    <= 1'b0;
            for (int i = 0; i < 8; i++) gr_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zf_q    <= zf_d;
            for (int i = 0; i < 8; i++) gr_q[i] <= gr_d[i];
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed-vector bench for cpu.
// Drives and samples on the falling clock edge.
module tb_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        en_ram_out;
    logic [15:0] ins;
    logic        en_ram_in;
    logic [15:0] addr;

    int total = 0;
    int bad   = 0;

    cpu dut (
        .clk        (clk),
        .rst        (rst),
        .en_in      (en_in),
        .en_ram_out (en_ram_out),
        .ins        (ins),
        .en_ram_in  (en_ram_in),
        .addr       (addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Called while in FETCH: complete one fetch/execute pair.
    task automatic run_ins(input logic [15:0] w);
        ins        = w;
        en_ram_out = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic chk_regs_zero(input string tag);
        for (int i = 0; i < 8; i++) chk(tag, dut.gr[i], 16'h0000);
    endtask

    initial begin
        rst        = 1'b0;
        en_in      = 1'b0;
        en_ram_out = 1'b0;
        ins        = 16'h0001;
        cyc();
        rst = 1'b1;
        chk("rst_addr", addr, 16'h0000);
        chk("rst_en", {15'b0, en_ram_in}, 16'h0000);
        chk("rst_zf", {15'b0, dut.zf}, 16'h0000);
        chk("rst_ir", dut.ir, 16'h0000);
        chk_regs_zero("rst_gr");

        for (int i = 0; i < 400; i++) begin
            cyc();
            chk("idle_addr", addr, 16'h0000);
            chk("idle_en", {15'b0, en_ram_in}, 16'h0000);
            chk("idle_st", {14'b0, dut.state}, 16'h0000);
        end

        // NOP stream
        en_in      = 1'b1;
        en_ram_out = 1'b1;
        ins        = 16'h0001;
        cyc();
        en_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("nop_en1", {15'b0, en_ram_in}, 16'h0001);
            chk("nop_a1", addr, 16'(k));
            cyc();
            chk("nop_en0", {15'b0, en_ram_in}, 16'h0000);
            chk("nop_a0", addr, 16'(k + 1));
            cyc();
        end
        chk_regs_zero("nop_gr");
        chk("nop_pc", addr, 16'h0004);

        // ALU sequence
        run_ins(16'h0C05);
        chk("ldi_r4", dut.gr[4], 16'h0005);
        run_ins(16'h1390);
        chk("add_r3", dut.gr[3], 16'h000A);
        chk("add_zf", {15'b0, dut.zf}, 16'h0000);
        run_ins(16'h1A90);
        chk("sub_r2", dut.gr[2], 16'h0000);
        chk("sub_zf", {15'b0, dut.zf}, 16'h0001);
        chk("alu_pc", addr, 16'h0007);

        // BZ taken backwards: pc 8 - 2 = 6
        run_ins(16'hB0FE);
        chk("bz_addr", addr, 16'h0006);

        // LDI 0xFF, ADDI 1 crosses the byte, then ADD r1,r1,r1
        run_ins(16'h09FF);
        chk("ldi_r1", dut.gr[1], 16'h00FF);
        chk("ldi_zf", {15'b0, dut.zf}, 16'h0001);
        run_ins(16'h4101);
        chk("addi_r1", dut.gr[1], 16'h0100);
        chk("addi_zf", {15'b0, dut.zf}, 16'h0000);
        run_ins(16'h1124);
        chk("dbl_r1", dut.gr[1], 16'h0200);
        chk("dbl_pc", addr, 16'h0009);

        // BZ not taken (zf=0)
        run_ins(16'hB0FE);
        chk("bznt_pc", addr, 16'h000A);

        // Jump
        run_ins(16'hAFC2);
        chk("jmp_addr", addr, 16'h07C2);
        chk("jmp_en", {15'b0, en_ram_in}, 16'h0001);

        // Fetch stall
        en_ram_out = 1'b0;
        ins        = 16'h0D07;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stl_en", {15'b0, en_ram_in}, 16'h0001);
            chk("stl_addr", addr, 16'h07C2);
            chk("stl_pc", dut.pc, 16'h07C2);
            chk("stl_ir", dut.ir, 16'hAFC2);
        end
        run_ins(16'h0001);
        chk("res_addr", addr, 16'h07C3);

        // Halt
        run_ins(16'hF800);
        chk("hlt_st", {14'b0, dut.state}, 16'h0003);
        en_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hlt_en", {15'b0, en_ram_in}, 16'h0000);
            chk("hlt_addr", addr, 16'h07C4);
            chk("hlt_st", {14'b0, dut.state}, 16'h0003);
        end
        en_in = 1'b0;

        // Leave HALT via reset, run one LDI, then reset mid-fetch
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("hrst_st", {14'b0, dut.state}, 16'h0000);
        chk("hrst_addr", addr, 16'h0000);
        en_in = 1'b1;
        cyc();
        en_in = 1'b0;
        run_ins(16'h0D07);
        chk("ldi_r5", dut.gr[5], 16'h0007);
        chk("ldi_pc", addr, 16'h0001);
        ins        = 16'h1390;
        en_ram_out = 1'b1;
        rst        = 1'b0;
        cyc();
        rst = 1'b1;
        en_ram_out = 1'b0;
        chk("mrst_st", {14'b0, dut.state}, 16'h0000);
        chk("mrst_addr", addr, 16'h0000);
        chk("mrst_en", {15'b0, en_ram_in}, 16'h0000);
        chk("mrst_ir", dut.ir, 16'h0000);
        chk("mrst_zf", {15'b0, dut.zf}, 16'h0000);
        chk_regs_zero("mrst_gr");
        cyc();
        chk("mrst_idle", {14'b0, dut.state}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
